// File: rtl/pixel_arb_pkg.sv
// Shared types and constants for the framebuffer write-port arbiter.
package pixel_arb_pkg;

   localparam int X_W               = 10;
   localparam int Y_W               = 9;
   localparam int H_DEFAULT         = 640;
   localparam int V_DEFAULT         = 480;
   localparam int CLR_BURST_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      YIELD
   } arb_state_t;

endpackage

// File: rtl/clear_sweep_counter.sv
// Raster-order x/y position generator for the screen-clear engine.
// The position moves only on 'advance'. After the final location
// (H-1, V-1) has been used, 'done' latches and the position freezes
// until the next 'restart'.
module clear_sweep_counter
   import pixel_arb_pkg::*;
#(
   parameter int H = H_DEFAULT,
   parameter int V = V_DEFAULT
) (
   input  logic           CLOCK_50,
   input  logic           HRESETn,
   input  logic           restart,
   input  logic           advance,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           last,
   output logic           done
);

   localparam logic [X_W-1:0] X_MAX = X_W'(H - 1);
   localparam logic [Y_W-1:0] Y_MAX = Y_W'(V - 1);

   assign last = (x == X_MAX) && (y == Y_MAX);

   // Step the sweep position in raster order; restart wins over advance.
   always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
      if (!HRESETn) begin
         x    <= '0;
         y    <= '0;
         done <= 1'b0;
      end else if (restart) begin
         x    <= '0;
         y    <= '0;
         done <= 1'b0;
      end else if (advance && !done) begin
         if (last) begin
            done <= 1'b1;
         end else if (x == X_MAX) begin
            x <= '0;
            y <= y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Shares the framebuffer write port between CPU pixel writes and the
// full-screen clear engine. During a clear, the CPU is guaranteed a slot
// after at most CLR_BURST consecutive clear writes.
module pixel_write_arbiter
   import pixel_arb_pkg::*;
#(
   parameter int H_PIXELS  = H_DEFAULT,
   parameter int V_PIXELS  = V_DEFAULT,
   parameter int CLR_BURST = CLR_BURST_DEFAULT
) (
   input  logic           CLOCK_50,
   input  logic           HRESETn,
   input  logic           cpu_req,
   input  logic [X_W-1:0] cpu_x,
   input  logic [Y_W-1:0] cpu_y,
   input  logic           cpu_pixel,
   output logic           cpu_ack,
   input  logic           clr_start,
   input  logic           clr_value,
   output logic           clr_busy,
   output logic           clr_done,
   output logic           out_we,
   output logic [X_W-1:0] out_x,
   output logic [Y_W-1:0] out_y,
   output logic           out_pixel,
   input  logic           out_ready
);

   localparam int            BW        = $clog2(CLR_BURST + 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(CLR_BURST);

   arb_state_t     state, state_next;
   logic [BW-1:0]  burst_cnt;
   logic           load_en;
   logic           sel_cpu, sel_clr, clr_accept;
   logic           last_accepted;
   logic           out_last;
   logic           clr_value_q;
   logic [X_W-1:0] sweep_x;
   logic [Y_W-1:0] sweep_y;
   logic           sweep_last, sweep_done;

   assign load_en       = !out_we || out_ready;
   assign last_accepted = out_we && out_ready && out_last;
   assign clr_busy      = (state != IDLE);

   clear_sweep_counter #(
      .H (H_PIXELS),
      .V (V_PIXELS)
   ) u_sweep (
      .CLOCK_50 (CLOCK_50),
      .HRESETn  (HRESETn),
      .restart  (clr_accept),
      .advance  (sel_clr),
      .x        (sweep_x),
      .y        (sweep_y),
      .last     (sweep_last),
      .done     (sweep_done)
   );

   // Next-state and source selection for the output register.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a latch.
      state_next = state;
      sel_cpu    = 1'b0;
      sel_clr    = 1'b0;
      clr_accept = 1'b0;
      case (state)
         IDLE: begin
            sel_cpu = load_en && cpu_req;
            if (clr_start) begin
               clr_accept = 1'b1;
               state_next = CLEAR;
            end
         end
         CLEAR: begin
            if (burst_cnt == BURST_MAX && cpu_req) begin
               // Grant the CPU right away when the port is free; if the
               // port is stalled, park in YIELD so no clear write slips in.
               if (load_en) sel_cpu = 1'b1;
               else         state_next = YIELD;
            end else begin
               sel_clr = load_en && !sweep_done;
            end
            if (last_accepted) state_next = IDLE;
         end
         YIELD: begin
            sel_cpu = load_en && cpu_req;
            if (load_en) state_next = last_accepted ? IDLE : CLEAR;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!HRESETn) state <= IDLE;
      else          state <= state_next;
   end

   // Burst counter: clear writes since the last CPU grant, saturating.
   always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
      if (!HRESETn)                            burst_cnt <= '0;
      else if (clr_accept || sel_cpu)          burst_cnt <= '0;
      else if (sel_clr && burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
   end

   // Clear pixel value is latched only when a clear is actually started.
   always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
      if (!HRESETn)        clr_value_q <= 1'b0;
      else if (clr_accept) clr_value_q <= clr_value;
   end

   // Output register: loads the selected write, or drops out_we when idle.
   always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
      if (!HRESETn) begin
         out_we    <= 1'b0;
         out_x     <= '0;
         out_y     <= '0;
         out_pixel <= 1'b0;
         out_last  <= 1'b0;
      end else if (load_en) begin
         if (sel_cpu) begin
            out_we    <= 1'b1;
            out_x     <= cpu_x;
            out_y     <= cpu_y;
            out_pixel <= cpu_pixel;
            out_last  <= 1'b0;
         end else if (sel_clr) begin
            out_we    <= 1'b1;
            out_x     <= sweep_x;
            out_y     <= sweep_y;
            out_pixel <= clr_value_q;
            out_last  <= sweep_last;
         end else begin
            out_we    <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

   // Handshake pulses: CPU capture acknowledge and end-of-clear.
   always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
      if (!HRESETn) begin
         cpu_ack  <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         cpu_ack  <= sel_cpu;
         clr_done <= last_accepted;
      end
   end

endmodule
